stage_buffer: RTL and testbench

STAGE_BUFFER -- requirements
Module: stage_buffer

---
 rtl/stage_buffer.sv | 101 ++++++++++
 tb/tb_stage_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/stage_buffer.sv
// stage_buffer: elastic pipeline buffer built as a circular array of DEPTH
// entries. It uses a valid/ready handshake on both sides and supports a
// synchronous flush.
//
// Optional feature: define STAGE_BUFFER_BYPASS_EN to let an input pass straight
// to the output in the same cycle when the buffer is empty and downstream is
// ready. Without it, in_data has no combinational path to out_data.
module stage_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             live_q, live_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic bypass;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake outputs; in_ready depends only on state and flush, never on out_ready
    always_comb begin
        in_ready = live_q && (count_q != CW'(DEPTH)) && !flush;
`ifdef STAGE_BUFFER_BYPASS_EN
        bypass   = (count_q == '0) && in_valid && out_ready && in_ready;
        out_valid = ((count_q != '0) && !flush) || bypass;
        out_data  = bypass ? in_data : mem_q[rd_ptr_q];
`else
        bypass    = 1'b0;
        out_valid = (count_q != '0) && !flush;
        out_data  = mem_q[rd_ptr_q];
`endif
        // A bypassed transfer leaves storage, pointers and count untouched
        push = in_valid && in_ready && !bypass;
        pop  = out_valid && out_ready && !bypass;
    end

    // Next-state for pointers, occupancy and the post-reset ready flag
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        live_d   = 1'b1;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_next(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_next(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            live_q   <= live_d;
        end
    end

    // Entry storage is not reset; contents only matter once counted
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign count = count_q;

endmodule

// File: tb/tb_stage_buffer.sv
// tb_stage_buffer: scoreboard bench for stage_buffer. It uses a DEPTH=2 and a
// DEPTH=3 instance with 8-bit payloads. Honors STAGE_BUFFER_BYPASS_EN when it
// is defined for the build.
module tb_stage_buffer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic       iv2 = 0, ir2, ov2, or2 = 0, f2 = 0;
    logic [7:0] id2 = 0, od2;
    logic [1:0] cnt2;
    logic       iv3 = 0, ir3, ov3, or3 = 0, f3 = 0;
    logic [7:0] id3 = 0, od3;
    logic [1:0] cnt3;

    stage_buffer #(.WIDTH(8), .DEPTH(2)) dut2 (
        .clk(clk), .resetn(resetn), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2), .flush(f2), .count(cnt2));

    stage_buffer #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk(clk), .resetn(resetn), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3), .flush(f3), .count(cnt3));

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] q2[$];
    logic [7:0] q3[$];
    int pops2 = 0, pops3 = 0;
    logic m_init;
    logic e_ir, e_ov;
    logic acc3 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", tag, got, exp);
    endtask

    // Model of the post-reset ready qualifier: ready from the first edge after release
    always @(posedge clk or negedge resetn) begin
        if (!resetn) m_init <= 1'b0;
        else         m_init <= 1'b1;
    end

    // Mid-cycle monitor: check handshake state, push accepted data, pop and compare outputs
    always @(negedge clk) begin
        e_ir = m_init && (q2.size() < 2) && !f2;
        e_ov = (q2.size() != 0) && !f2;
`ifdef STAGE_BUFFER_BYPASS_EN
        if (q2.size() == 0 && iv2 && or2 && e_ir) e_ov = 1'b1;
`endif
        chk("d2_in_ready", 32'(ir2), 32'(e_ir));
        chk("d2_out_valid", 32'(ov2), 32'(e_ov));
        chk("d2_count", 32'(cnt2), q2.size());
        if (e_ir && iv2) q2.push_back(id2);
        if (e_ov && or2) begin
            chk("d2_out_data", 32'(od2), 32'(q2.pop_front()));
            pops2++;
        end
        if (f2) q2.delete();

        e_ir = m_init && (q3.size() < 3) && !f3;
        e_ov = (q3.size() != 0) && !f3;
`ifdef STAGE_BUFFER_BYPASS_EN
        if (q3.size() == 0 && iv3 && or3 && e_ir) e_ov = 1'b1;
`endif
        chk("d3_in_ready", 32'(ir3), 32'(e_ir));
        chk("d3_out_valid", 32'(ov3), 32'(e_ov));
        chk("d3_count", 32'(cnt3), q3.size());
        acc3 = e_ir && iv3;
        if (acc3) q3.push_back(id3);
        if (e_ov && or3) begin
            chk("d3_out_data", 32'(od3), 32'(q3.pop_front()));
            pops3++;
        end
        if (f3) q3.delete();
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int v;
    int guard;

    initial begin
        // Reset held for a few cycles
        repeat (3) cyc();
        chk("rst_out_valid", 32'(ov2), 0);
        chk("rst_in_ready", 32'(ir2), 0);
        chk("rst_count", 32'(cnt3), 0);
        @(posedge clk); #2 resetn = 1'b1;
        cyc(); cyc();
        chk("post_rst_in_ready", 32'(ir2), 1);

        // Fill and drain on DEPTH=2
        or2 = 0; iv2 = 1; id2 = 8'hA1;
        cyc(); id2 = 8'hB2;
        cyc(); id2 = 8'hC3;
        #2;
        chk("fill_count", 32'(cnt2), 2);
        chk("fill_in_ready", 32'(ir2), 0);
        cyc();
        iv2 = 0; or2 = 1;
        #2 chk("drain_first", 32'(od2), 32'h A1);
        cyc();
        #2 chk("drain_second", 32'(od2), 32'h B2);
        cyc(); cyc();
        chk("drain_count", 32'(cnt2), 0);
        chk("drain_pops", pops2, 2);
        or2 = 0;

        // Simultaneous push and pop at count=1
        iv2 = 1; id2 = 8'h11;
        cyc(); id2 = 8'h22; or2 = 1;
        #2 chk("pp_popped", 32'(od2), 32'h11);
        cyc(); iv2 = 0; or2 = 0;
        #2;
        chk("pp_count", 32'(cnt2), 1);
        chk("pp_next_data", 32'(od2), 32'h22);
        or2 = 1;
        cyc(); or2 = 0;

        // Flush with push and pop offered
        iv2 = 1; id2 = 8'h33;
        cyc(); id2 = 8'h44;
        cyc(); iv2 = 1; id2 = 8'h55; or2 = 1; f2 = 1;
        #2 chk("flush_out_valid", 32'(ov2), 0);
        cyc(); f2 = 0; iv2 = 0;
        #2;
        chk("flush_count", 32'(cnt2), 0);
        chk("flush_out_valid_after", 32'(ov2), 0);
        repeat (3) cyc();
        or2 = 0;

        // Bypass (or one-cycle latency without the macro) on an empty buffer
        iv2 = 1; id2 = 8'h7E; or2 = 1;
        #2;
`ifdef STAGE_BUFFER_BYPASS_EN
        chk("byp_out_valid", 32'(ov2), 1);
        chk("byp_out_data", 32'(od2), 32'h7E);
        chk("byp_count", 32'(cnt2), 0);
        cyc(); iv2 = 0;
        #2 chk("byp_count_after", 32'(cnt2), 0);
`else
        chk("lat_out_valid", 32'(ov2), 0);
        cyc(); iv2 = 0;
        #2;
        chk("lat_out_valid_next", 32'(ov2), 1);
        chk("lat_out_data_next", 32'(od2), 32'h7E);
`endif
        cyc(); or2 = 0;

        // Wrap-around on DEPTH=3 with out_ready toggling
        v = 1; guard = 0;
        iv3 = 1; id3 = 8'(v); or3 = 1;
        while (v <= 10 && guard < 200) begin
            cyc();
            guard++;
            if (acc3) v++;
            if (v <= 10) id3 = 8'(v);
            else iv3 = 0;
            or3 = ~or3;
        end
        chk("wrap_all_sent", v, 11);
        iv3 = 0; or3 = 1;
        repeat (8) cyc();
        chk("wrap_pops", pops3, 10);
        chk("wrap_count", 32'(cnt3), 0);
        or3 = 0;

        // Asynchronous reset with entries held
        iv2 = 1; id2 = 8'h61;
        cyc(); id2 = 8'h62;
        cyc(); iv2 = 0;
        #1 chk("ar_count_before", 32'(cnt2), 2);
        @(posedge clk); #3 resetn = 1'b0;
        #1;
        chk("ar_out_valid", 32'(ov2), 0);
        chk("ar_count", 32'(cnt2), 0);
        chk("ar_in_ready", 32'(ir2), 0);
        q2.delete(); q3.delete();
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
        cyc(); #1;
        chk("ar_rel_in_ready", 32'(ir2), 1);
        chk("ar_rel_out_valid", 32'(ov2), 0);
        cyc();

        chk("end_q2_empty", q2.size(), 0);
        chk("end_q3_empty", q3.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
